// File: rtl/pio_ex_pkg.sv
// Shared types and constants for the PIO bank exerciser.
package pio_ex_pkg;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_DRIVE = 2'd1,
      PH_TURN  = 2'd2,
      PH_SENSE = 2'd3
   } phase_e;

   localparam logic [1:0] MODE_IN    = 2'b00;
   localparam logic [1:0] MODE_OUT   = 2'b01;
   localparam logic [1:0] MODE_BIDIR = 2'b10;

   localparam int CNT_W = 16;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction

endpackage

// File: rtl/pio_ex_chan.sv
// One pad channel: mode decode, registered pad drive, input synchroniser,
// expected-value delay line and loopback mismatch flag.
module pio_ex_chan
   import pio_ex_pkg::*;
#(
   parameter logic [1:0] CH_MODE = MODE_IN
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic drive_i,   // next cycle is a DRIVE cycle
   input  logic active_i,  // next cycle is not IDLE
   input  logic pat_i,     // LFSR bit for this channel
   input  logic check_i,   // loopback compare window open this cycle
   input  logic pad_i,
   output logic pad_o,
   output logic pad_t_o,
   output logic sync_o,
   output logic mism_o
);

   localparam logic IS_OUT   = (CH_MODE == MODE_OUT);
   localparam logic IS_BIDIR = (CH_MODE == MODE_BIDIR);

   logic       pad_o_q, pad_o_d;
   logic       pad_t_q, pad_t_d;
   logic [1:0] sync_q;
   logic [1:0] exp_q;

   // Pad drive next value; bidir releases as soon as DRIVE ends.
   always_comb begin
      pad_o_d = 1'b0;
      pad_t_d = 1'b1;
      if (IS_OUT || IS_BIDIR) begin
         if (drive_i)        pad_o_d = pat_i;
         else if (active_i)  pad_o_d = pad_o_q;
         else                pad_o_d = 1'b0;
      end
      if (IS_OUT)        pad_t_d = !active_i;
      else if (IS_BIDIR) pad_t_d = !drive_i;
   end

   // Pad registers, synchroniser and expected-value delay line.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pad_o_q <= 1'b0;
         pad_t_q <= 1'b1;
         sync_q  <= '0;
         exp_q   <= '0;
      end else begin
         pad_o_q <= pad_o_d;
         pad_t_q <= pad_t_d;
         sync_q  <= {sync_q[0], pad_i};
         exp_q   <= {exp_q[0], pad_o_q};
      end
   end

   assign pad_o   = pad_o_q;
   assign pad_t_o = pad_t_q;
   assign sync_o  = sync_q[1];
   // Both the synchronised pad and the delayed drive value are two cycles old.
   assign mism_o  = check_i && IS_BIDIR && (sync_q[1] != exp_q[1]);

endmodule

// File: rtl/pio_bank_exerciser.sv
// Multi-channel PIO exerciser: DRIVE/TURN/SENSE sequencer, shared LFSR
// pattern, bidir loopback error counter and sensed-level capture.
//
// state    | meaning
// ---------+---------------------------------------------------------
// PH_IDLE  | pads released, LFSR held at seed, waiting for en
// PH_DRIVE | outputs and bidirs drive the LFSR pattern, loopback checked
// PH_TURN  | bidirs released, outputs hold, bus settles
// PH_SENSE | pads sampled; last cycle captures sense_data
module pio_bank_exerciser
   import pio_ex_pkg::*;
#(
   parameter int                 NCH       = 4,
   parameter logic [2*NCH-1:0]   MODE      = '0,
   parameter int                 DRIVE_LEN = 64,
   parameter int                 TURN_LEN  = 4,
   parameter int                 SENSE_LEN = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [NCH-1:0]   pad_i,
   output logic [NCH-1:0]   pad_o,
   output logic [NCH-1:0]   pad_t,
   output logic [NCH-1:0]   sense_data,
   output logic [15:0]      err_cnt,
   output logic [1:0]       phase,
   output logic             round_done
);

   phase_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [15:0]       err_q, err_d;
   logic [NCH-1:0]    sense_q, sense_d;
   logic [NCH-1:0]    sync, mism;
   logic              done_q, done_d;
   logic              cnt_last, drive_nx, active_nx, check, load_sense;

   function automatic logic [CNT_W-1:0] reload(input phase_e s);
      case (s)
         PH_DRIVE: return CNT_W'(DRIVE_LEN - 1);
         PH_TURN:  return CNT_W'(TURN_LEN - 1);
         PH_SENSE: return CNT_W'(SENSE_LEN - 1);
         default:  return '0;
      endcase
   endfunction

   assign cnt_last = (cnt_q == '0);

   // State and phase counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PH_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state; the counter reloads on every state entry and counts down.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         PH_IDLE:  if (en) state_d = PH_DRIVE;
         PH_DRIVE: if (!en) state_d = PH_IDLE; else if (cnt_last) state_d = PH_TURN;
         PH_TURN:  if (!en) state_d = PH_IDLE; else if (cnt_last) state_d = PH_SENSE;
         PH_SENSE: if (cnt_last) state_d = en ? PH_DRIVE : PH_IDLE;
         default:  state_d = PH_IDLE;
      endcase
      if (state_d != state_q) cnt_d = reload(state_d);
      else if (!cnt_last)     cnt_d = cnt_q - CNT_W'(1);
   end

   // FSM-derived controls; pad controls look at the next state so pads
   // change in the same cycle phase does.
   always_comb begin
      drive_nx   = (state_d == PH_DRIVE);
      active_nx  = (state_d != PH_IDLE);
      // First three DRIVE cycles still see stale pad levels in the pipeline.
      check      = (state_q == PH_DRIVE) && (cnt_q <= CNT_W'(DRIVE_LEN - 4));
      load_sense = (state_q == PH_SENSE) && cnt_last;
   end

   // Datapath next values: LFSR, saturating error count, sense capture.
   always_comb begin
      lfsr_d  = lfsr_q;
      err_d   = err_q;
      sense_d = sense_q;
      done_d  = load_sense;
      if (state_d == PH_IDLE) lfsr_d = LFSR_SEED;
      else if (drive_nx)      lfsr_d = lfsr_step(lfsr_q);
      if ((|mism) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
      if (load_sense) sense_d = sync;
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q  <= LFSR_SEED;
         err_q   <= '0;
         sense_q <= '0;
         done_q  <= 1'b0;
      end else begin
         lfsr_q  <= lfsr_d;
         err_q   <= err_d;
         sense_q <= sense_d;
         done_q  <= done_d;
      end
   end

   for (genvar k = 0; k < NCH; k++) begin : g_chan
      pio_ex_chan #(.CH_MODE(MODE[2*k +: 2])) u_chan (
         .clk_i    (clk),
         .rst_i    (rst),
         .drive_i  (drive_nx),
         .active_i (active_nx),
         .pat_i    (lfsr_q[k]),
         .check_i  (check),
         .pad_i    (pad_i[k]),
         .pad_o    (pad_o[k]),
         .pad_t_o  (pad_t[k]),
         .sync_o   (sync[k]),
         .mism_o   (mism[k])
      );
   end

   assign phase      = state_q;
   assign err_cnt    = err_q;
   assign sense_data = sense_q;
   assign round_done = done_q;

endmodule

// File: tb/tb_pio_bank_exerciser.sv
// Directed bench for pio_bank_exerciser. dut: 4 channels (in/out/bidir/bidir)
// with pad loopback; dut_sat: one bidir channel looped inverted with a long
// DRIVE phase so the error counter reaches saturation.
module tb_pio_bank_exerciser;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en;
   logic [3:0]  pad_i, pad_o, pad_t, sense_data;
   logic [15:0] err_cnt;
   logic [1:0]  phase;
   logic        round_done;
   logic [3:0]  ext, stuck;

   logic        rst2, en2;
   logic [0:0]  pad_i2, pad_o2, pad_t2, sense2;
   logic [15:0] err2;
   logic [1:0]  phase2;
   logic        rd2;
   logic        sat_done = 1'b0;

   int n_chk = 0;
   int n_bad = 0;

   pio_bank_exerciser #(
      .NCH(4), .MODE(8'b10_10_01_00), .DRIVE_LEN(64), .TURN_LEN(4), .SENSE_LEN(8)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .pad_i(pad_i), .pad_o(pad_o), .pad_t(pad_t),
      .sense_data(sense_data), .err_cnt(err_cnt), .phase(phase), .round_done(round_done)
   );

   pio_bank_exerciser #(
      .NCH(1), .MODE(2'b10), .DRIVE_LEN(16384), .TURN_LEN(4), .SENSE_LEN(8)
   ) dut_sat (
      .clk(clk), .rst(rst2), .en(en2), .pad_i(pad_i2), .pad_o(pad_o2), .pad_t(pad_t2),
      .sense_data(sense2), .err_cnt(err2), .phase(phase2), .round_done(rd2)
   );

   // Pad model: a driven pad reads back its own value unless stuck low.
   always_comb begin
      pad_i = '0;
      for (int k = 0; k < 4; k++)
         pad_i[k] = stuck[k] ? 1'b0 : (pad_t[k] ? ext[k] : pad_o[k]);
   end
   assign pad_i2 = ~pad_o2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] m_next(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   function automatic logic [15:0] m_pat(input int j);
      logic [15:0] l = 16'hACE1;
      for (int i = 0; i < j; i++) l = m_next(l);
      return l;
   endfunction

   // A checked cycle i (3..63) compares the value driven in DRIVE cycle i-2.
   function automatic int m_ch3_err(input int rounds);
      int          cnt = 0;
      logic [15:0] p;
      for (int r = 0; r < rounds; r++)
         for (int i = 1; i <= 61; i++) begin
            p = m_pat(64*r + i);
            if (p[3]) cnt++;
         end
      return cnt;
   endfunction

   initial begin
      int          rd_q[$];
      int          n, r0, r1, r2;
      logic [15:0] p;
      logic [3:0]  sense_exp;

      rst = 1'b1; en = 1'b0; ext = '0; stuck = '0;
      tick(); tick();
      chk("rst_pad_t", pad_t, 4'hF);
      chk("rst_pad_o", pad_o, 4'h0);
      chk("rst_phase", phase, 2'd0);
      chk("rst_err", err_cnt, 16'h0);
      chk("rst_sense", sense_data, 4'h0);
      chk("rst_done", round_done, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_pad_t", pad_t, 4'hF);
         chk("idle_pad_o", pad_o, 4'h0);
         chk("idle_phase", phase, 2'd0);
         chk("idle_err", err_cnt, 16'h0);
      end

      // Three full rounds with loopback.
      en = 1'b1;
      for (int c = 1; c <= 235; c++) begin
         tick();
         if (round_done) rd_q.push_back(c);
         if (c == 1) begin
            // LFSR nibble is 4'h1, but ch0 is an input so pad_o shows 0.
            chk("first_nib", pad_o, 4'h0);
            chk("drive_phase", phase, 2'd1);
            chk("drive_pad_t", pad_t, 4'b0001);
         end
         if (c >= 2 && c <= 6) begin
            p = m_pat(c - 1);
            chk("drive_pat", pad_o, p[3:0] & 4'b1110);
         end
         if (c == 64) chk("last_drive", phase, 2'd1);
         if (c == 65) begin
            chk("turn_phase", phase, 2'd2);
            chk("turn_pad_t", pad_t, 4'b1101);
         end
         if (c == 69) chk("sense_phase", phase, 2'd3);
      end
      r0 = (rd_q.size() > 0) ? rd_q[0] : -1;
      r1 = (rd_q.size() > 1) ? rd_q[1] : -1;
      r2 = (rd_q.size() > 2) ? rd_q[2] : -1;
      chk("rd_count", rd_q.size(), 3);
      chk("rd_first", r0, 77);
      chk("rd_gap1", r1 - r0, 76);
      chk("rd_gap2", r2 - r1, 76);
      chk("loop_err", err_cnt, 16'h0);

      // Drop en mid-DRIVE.
      en = 1'b0;
      tick();
      chk("abort_phase", phase, 2'd0);
      chk("abort_pad_t", pad_t, 4'hF);
      chk("abort_done", round_done, 1'b0);

      // Channel 3 stuck low for two rounds.
      rst = 1'b1; tick(); rst = 1'b0;
      stuck = 4'b1000; en = 1'b1;
      n = 0;
      for (int c = 0; c < 400 && n < 2; c++) begin
         tick();
         if (round_done) n++;
      end
      chk("stuck_rounds", n, 2);
      chk("stuck_err", err_cnt, m_ch3_err(2));
      en = 1'b0; tick(); stuck = '0;

      // Sense capture: input ch0 high, bidir ch2 pulled high.
      rst = 1'b1; tick(); rst = 1'b0;
      ext = 4'b0101; en = 1'b1;
      n = 0;
      for (int c = 0; c < 200 && n < 1; c++) begin
         tick();
         if (round_done) n++;
      end
      chk("sense_round", n, 1);
      p = m_pat(63);
      sense_exp = {1'b0, 1'b1, p[1], 1'b1};
      chk("sense_data", sense_data, sense_exp);
      en = 1'b0; ext = '0;
      tick(); tick(); tick();
      chk("sense_hold", sense_data, sense_exp);

      // Reset mid-TURN with en still high.
      rst = 1'b1; tick(); rst = 1'b0;
      stuck = 4'b1000; en = 1'b1;
      for (int c = 1; c <= 66; c++) tick();
      chk("pre_rst_phase", phase, 2'd2);
      chk("pre_rst_err", err_cnt, m_ch3_err(1));
      rst = 1'b1;
      tick();
      chk("mrst_phase", phase, 2'd0);
      chk("mrst_pad_t", pad_t, 4'hF);
      chk("mrst_pad_o", pad_o, 4'h0);
      chk("mrst_err", err_cnt, 16'h0);
      chk("mrst_done", round_done, 1'b0);
      tick();
      chk("rst_wins", phase, 2'd0);
      rst = 1'b0; en = 1'b0; stuck = '0;

      n = 0;
      while (!sat_done && n < 100000) begin
         tick();
         n++;
      end
      chk("sat_finished", sat_done, 1'b1);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   // Saturation run on the second instance, in parallel with the above.
   initial begin
      int n;
      rst2 = 1'b1; en2 = 1'b0;
      tick(); tick();
      rst2 = 1'b0; en2 = 1'b1;
      n = 0;
      while (!rd2 && n < 17000) begin
         tick();
         n++;
      end
      chk("sat_round1", err2, 16'd16381);
      n = 0;
      while (err2 != 16'hFFFE && n < 60000) begin
         tick();
         n++;
      end
      chk("sat_fffe", err2, 16'hFFFE);
      tick();
      chk("sat_ffff", err2, 16'hFFFF);
      repeat (300) tick();
      chk("sat_hold", err2, 16'hFFFF);
      sat_done = 1'b1;
   end

endmodule

// File: doc/pio_bank_exerciser.md
# pio_bank_exerciser

Parametrised multi-channel PIO exerciser for ECP5 I/O fuzzing and bring-up. Drives and observes `NCH` pad channels, each fixed at build time as input, output or bidirectional. Runs a repeating DRIVE/TURN/SENSE cycle with a shared LFSR pattern, checks bidir loopback, and captures input levels. Sits directly below the top level, which wraps each channel's `pad_o`/`pad_t`/`pad_i` in a BB/OB/IB primitive carrying its LOC and IO_TYPE attributes.

## Interface
- `NCH`, 4: channel count, 1..16.
- `MODE`, 0: `2*NCH`-bit vector; channel k uses bits [2k+1:2k]. 00 = input, 01 = output, 10 = bidir, 11 = reserved (treated as input).
- `DRIVE_LEN`, 64: DRIVE phase length in cycles, ≥ 4.
- `TURN_LEN`, 4: TURN phase length in cycles, ≥ 1.
- `SENSE_LEN`, 8: SENSE phase length in cycles, ≥ 3.
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: run enable.
- `pad_i`  in  NCH: pad input level from the I/O buffer (asynchronous).
- `pad_o`  out  NCH: pad output data.
- `pad_t`  out  NCH: tristate control, 1 = released (high-Z).
- `sense_data`  out  NCH: synchronised pad levels captured at the end of SENSE.
- `err_cnt`  out  16: saturating loopback mismatch count.
- `phase`  out  2: 0 IDLE, 1 DRIVE, 2 TURN, 3 SENSE.
- `round_done`  out  1: one-cycle pulse on SENSE→DRIVE/IDLE.

## Operation
- Global FSM states: IDLE, DRIVE, TURN, SENSE. One phase counter, reloaded on each state entry.
- IDLE → DRIVE when `en`=1. DRIVE → TURN after `DRIVE_LEN` cycles. TURN → SENSE after `TURN_LEN` cycles. SENSE → DRIVE after `SENSE_LEN` cycles if `en`=1, otherwise SENSE → IDLE.
- `en`=0 in DRIVE or TURN: next state is IDLE and no `round_done` pulse.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 loaded on reset and in IDLE. Advances once per DRIVE cycle. Channel k is driven from bit k.
- Output channels: `pad_t`=0 in every non-IDLE state. `pad_o` follows the LFSR in DRIVE and holds its last value in TURN and SENSE.
- Bidir channels: `pad_t`=0 and `pad_o` = LFSR bit in DRIVE. `pad_t`=1 in TURN and SENSE.
- Input and reserved channels: `pad_t`=1 and `pad_o`=0 always.
- Every `pad_i` bit passes through a 2-flop synchroniser.
- Loopback check applies to bidir channels only. The synchronised input is compared with the registered `pad_o` delayed 2 cycles. The compare is masked for the first 3 DRIVE cycles of each round and evaluated on every later DRIVE cycle.
- `err_cnt` increments by 1 per cycle in which any checked bidir channel mismatches, regardless of how many channels mismatch. It saturates at 16'hFFFF and is cleared only by `rst`.
- `sense_data` loads all NCH synchronised bits on the last SENSE cycle and holds otherwise.

## Timing
- All outputs are registered. Reset values: `pad_o`=0, `pad_t`=all 1, `sense_data`=0, `err_cnt`=0, `phase`=0, `round_done`=0, FSM=IDLE, LFSR=16'hACE1.
- `en` rises in cycle n: `phase`=1 and the first LFSR pattern appear at cycle n+1.
- `pad_t` for bidir channels rises in the same cycle `phase` becomes 2. There is no cycle in which a bidir channel drives outside DRIVE.
- `round_done` is asserted in the cycle `phase` leaves 3.
- `rst` mid-round takes effect at the next edge with reset values. Pads release in that cycle.
- `rst` and `en` both high: reset wins.

## Structure
- Package `pio_ex_pkg` holds:
  - the phase enum (IDLE/DRIVE/TURN/SENSE encodings 0..3);
  - the mode encodings (`MODE_IN`, `MODE_OUT`, `MODE_BIDIR`);
  - the LFSR seed and tap constants.
- Sub-module `pio_ex_chan` is instantiated NCH times. Each instance holds its mode decode, `pad_o`/`pad_t` registers, 2-flop synchroniser, 2-deep expected-value delay line and mismatch flag.
- The top holds the FSM, phase counter, LFSR, error counter and `sense_data`.

## Test plan
- Reset, then hold `en`=0 for 10 cycles. Required: `pad_t`=4'b1111, `pad_o`=0, `phase`=0, `err_cnt`=0 throughout.
- NCH=4, MODE=8'b10_10_01_00, `pad_i` looped to `pad_o` for bidir channels, `en`=1 for 3 rounds. Required:
  - `err_cnt`=0;
  - `round_done` pulses every 76 cycles;
  - the first DRIVE pattern nibble is 4'h1 (seed bits [3:0]).
- Same configuration with channel 3's `pad_i` tied to 0. Required: `err_cnt` equals the count of checked DRIVE cycles in which channel 3 was driven 1, accumulated over both rounds.
- Input channel 0 driven 1 and bidir channel 2 pulled 1 during SENSE. Required: `sense_data` bits 0 and 2 read 1 after `round_done`.
- Drop `en` mid-DRIVE. Required: `phase`=0 and all `pad_t`=1 on the next cycle, with no `round_done`. Raise `rst` mid-TURN: same response, and `err_cnt` cleared.
- Force `err_cnt` to 16'hFFFE via continuous mismatch. Required: `err_cnt` saturates at 16'hFFFF and holds.
